ber_test_controller: RTL and testbench

Sequences one bit-error-ratio test run around the PRBS pattern generator pair and the receive-side comparator.
- Latches the PRBS mode and drives the generators' select and reset.
- Waits for receive lock.
- Counts pattern words and errored bits over a programmed test length, then reports results with a done pulse.
- Sits between the host/config logic and the PRBS-7/PRBS-13 pattern path.

---
 rtl/ber_test_controller.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_ber_test_controller.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ber_test_controller.sv
`default_nettype none
// ============================================================================
//  Module      : ber_test_controller
//  Description : Sequences one bit-error-ratio test run around the PRBS-7 /
//                PRBS-13 pattern generator pair and the receive comparator.
//                Latches the pattern mode and test length on start, holds the
//                generators in reset while seeding, waits for receive lock,
//                then counts checked words and errored bits until the
//                programmed length is reached, and reports with a done pulse.
//
//  Ports       : clock        - system clock, rising edge
//                reset        - asynchronous, active-low reset
//                start        - begin a test (only honoured when idle)
//                abort        - cancel a running test
//                mode_sel     - 0 = PRBS-13, 1 = PRBS-7 (latched on start)
//                test_len     - number of rx words to check (latched on start)
//                rx_valid     - comparator word strobe
//                rx_err       - per-bit mismatch vector (expected ^ received)
//                prbs_control - latched mode select to the generators
//                gen_reset    - 1 holds the generators in reset
//                busy         - test in progress (seed / sync / run)
//                locked       - receive lock achieved (held until next start)
//                done         - one-cycle pulse at the end of a test
//                sync_fail    - sticky: lock not reached in time
//                aborted      - sticky: last test was cancelled
//                word_count   - words checked while running
//                err_count    - errored bits while running (saturating)
//                inject_req   - (ERR_INJECT_EN only) request one injected error
//                inject_mask  - (ERR_INJECT_EN only) single-bit error mask
//
//  Options     : define ERR_INJECT_EN to add the one-shot error injector.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module ber_test_controller #(
    parameter int PAT_W    = 13,
    parameter int CNT_W    = 32,
    parameter int ERR_W    = 24,
    parameter int LOCK_CNT = 16,
    parameter int SYNC_TMO = 1024,
    parameter int SEED_CYC = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             mode_sel,
    input  logic [CNT_W-1:0] test_len,
    input  logic             rx_valid,
    input  logic [PAT_W-1:0] rx_err,
`ifdef ERR_INJECT_EN
    input  logic             inject_req,
    output logic [PAT_W-1:0] inject_mask,
`endif
    output logic             prbs_control,
    output logic             gen_reset,
    output logic             busy,
    output logic             locked,
    output logic             done,
    output logic             sync_fail,
    output logic             aborted,
    output logic [CNT_W-1:0] word_count,
    output logic [ERR_W-1:0] err_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEED = 3'd1;
    localparam logic [2:0] S_SYNC = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int TMO_W  = $clog2(SYNC_TMO + 1);
    localparam int SEED_W = (SEED_CYC > 1) ? $clog2(SEED_CYC) : 1;
    localparam int POP_W  = $clog2(PAT_W + 1);
    localparam int ERR_W1 = ERR_W + 1;

    localparam logic [RUN_W-1:0]  LOCK_VAL  = RUN_W'(LOCK_CNT);
    localparam logic [TMO_W-1:0]  TMO_VAL   = TMO_W'(SYNC_TMO);
    localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(SEED_CYC - 1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [2:0]        state_q,      state_d;
    logic              mode_q,       mode_d;
    logic [CNT_W-1:0]  len_q,        len_d;
    logic [SEED_W-1:0] seed_cnt_q,   seed_cnt_d;
    logic [RUN_W-1:0]  run_cnt_q,    run_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q,    tmo_cnt_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;
    logic [ERR_W-1:0]  err_count_q,  err_count_d;
    logic              locked_q,     locked_d;
    logic              sync_fail_q,  sync_fail_d;
    logic              aborted_q,    aborted_d;

    // ------------------------------------------------------------------------
    // Popcount of the mismatch vector. All PAT_W bits are counted; in PRBS-7
    // mode the comparator is responsible for zeroing the unused upper bits.
    // ------------------------------------------------------------------------
    logic [POP_W-1:0]  pop_cnt;
    logic [ERR_W:0]    err_sum;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < PAT_W; i++) begin
            pop_cnt = pop_cnt + POP_W'(rx_err[i]);
        end
    end

    // One extra bit catches overflow so the counter can saturate at all-ones.
    assign err_sum = {1'b0, err_count_q} + ERR_W1'(pop_cnt);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        len_d        = len_q;
        seed_cnt_d   = seed_cnt_q;
        run_cnt_d    = run_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        word_count_d = word_count_q;
        err_count_d  = err_count_q;
        locked_d     = locked_q;
        sync_fail_d  = sync_fail_q;
        aborted_d    = aborted_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d       = mode_sel;
                    len_d        = test_len;
                    word_count_d = '0;
                    err_count_d  = '0;
                    locked_d     = 1'b0;
                    sync_fail_d  = 1'b0;
                    aborted_d    = 1'b0;
                    seed_cnt_d   = '0;
                    state_d      = S_SEED;
                end
            end

            S_SEED: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (seed_cnt_q == SEED_LAST) begin
                    // Both sync counters start fresh on entry to SYNC.
                    run_cnt_d = '0;
                    tmo_cnt_d = '0;
                    state_d   = S_SYNC;
                end else begin
                    seed_cnt_d = seed_cnt_q + SEED_W'(1);
                end
            end

            S_SYNC: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    if (rx_valid) begin
                        // Any errored word restarts the clean-word run.
                        run_cnt_d = (rx_err == '0) ? (run_cnt_q + RUN_W'(1)) : '0;
                    end
                    // Lock is checked first so a coincident timeout loses.
                    if (run_cnt_d == LOCK_VAL) begin
                        locked_d = 1'b1;
                        state_d  = S_RUN;
                    end else if (tmo_cnt_d == TMO_VAL) begin
                        sync_fail_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end

            S_RUN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (len_q == '0) begin
                    // Zero-length test finishes immediately without counting.
                    state_d = S_DONE;
                end else if (rx_valid) begin
                    word_count_d = word_count_q + CNT_W'(1);
                    if (err_sum[ERR_W]) begin
                        err_count_d = '1;
                    end else begin
                        err_count_d = err_sum[ERR_W-1:0];
                    end
                    if (word_count_d == len_q) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            len_q        <= '0;
            seed_cnt_q   <= '0;
            run_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            word_count_q <= '0;
            err_count_q  <= '0;
            locked_q     <= 1'b0;
            sync_fail_q  <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            len_q        <= len_d;
            seed_cnt_q   <= seed_cnt_d;
            run_cnt_q    <= run_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            word_count_q <= word_count_d;
            err_count_q  <= err_count_d;
            locked_q     <= locked_d;
            sync_fail_q  <= sync_fail_d;
            aborted_q    <= aborted_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded directly from registered state.
    // ------------------------------------------------------------------------
    assign prbs_control = mode_q;
    assign gen_reset    = (state_q != S_SYNC) && (state_q != S_RUN);
    assign busy         = (state_q == S_SEED) || (state_q == S_SYNC) || (state_q == S_RUN);
    assign done         = (state_q == S_DONE);
    assign locked       = locked_q;
    assign sync_fail    = sync_fail_q;
    assign aborted      = aborted_q;
    assign word_count   = word_count_q;
    assign err_count    = err_count_q;

`ifdef ERR_INJECT_EN
    // ------------------------------------------------------------------------
    // One-shot error injector: a request during RUN arms it, the next valid
    // word carries a single bit-0 error, then it disarms. Requests while
    // already armed simply merge into the pending injection.
    // ------------------------------------------------------------------------
    logic inj_armed_q, inj_armed_d;
    logic inj_fire;

    assign inj_fire = inj_armed_q && rx_valid && (state_q == S_RUN);

    always_comb begin
        inj_armed_d = inj_armed_q;
        if (state_q != S_RUN) begin
            inj_armed_d = 1'b0;
        end else if (inj_fire) begin
            inj_armed_d = 1'b0;
        end else if (inject_req) begin
            inj_armed_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inj_armed_q <= 1'b0;
        end else begin
            inj_armed_q <= inj_armed_d;
        end
    end

    assign inject_mask = {{(PAT_W-1){1'b0}}, inj_fire};
`endif

endmodule

`default_nettype wire

// File: tb/tb_ber_test_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ber_test_controller
//  Description : Self-checking bench for ber_test_controller. A phase-level
//                model of a test run predicts every output each cycle; a
//                compare process checks the DUT on the falling clock edge,
//                and directed scenarios add hand-computed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ber_test_controller;

    localparam int PAT_W    = 13;
    localparam int CNT_W    = 32;
    localparam int ERR_W    = 24;
    localparam int LOCK_CNT = 16;
    localparam int SYNC_TMO = 1024;
    localparam int SEED_CYC = 2;
    localparam longint ERR_MAX = (64'd1 << ERR_W) - 1;

    logic             clock    = 1'b0;
    logic             reset    = 1'b0;
    logic             start    = 1'b0;
    logic             abort    = 1'b0;
    logic             mode_sel = 1'b0;
    logic [CNT_W-1:0] test_len = '0;
    logic             rx_valid = 1'b0;
    logic [PAT_W-1:0] rx_err_drv = '0;
    logic [PAT_W-1:0] rx_err;

    logic             prbs_control, gen_reset, busy, locked, done, sync_fail, aborted;
    logic [CNT_W-1:0] word_count;
    logic [ERR_W-1:0] err_count;

`ifdef ERR_INJECT_EN
    logic             inject_req = 1'b0;
    logic [PAT_W-1:0] inject_mask;
    logic             loop_en = 1'b0;
    assign rx_err = rx_err_drv ^ (loop_en ? inject_mask : '0);
`else
    assign rx_err = rx_err_drv;
`endif

    ber_test_controller #(
        .PAT_W(PAT_W), .CNT_W(CNT_W), .ERR_W(ERR_W),
        .LOCK_CNT(LOCK_CNT), .SYNC_TMO(SYNC_TMO), .SEED_CYC(SEED_CYC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .mode_sel     (mode_sel),
        .test_len     (test_len),
        .rx_valid     (rx_valid),
        .rx_err       (rx_err),
`ifdef ERR_INJECT_EN
        .inject_req   (inject_req),
        .inject_mask  (inject_mask),
`endif
        .prbs_control (prbs_control),
        .gen_reset    (gen_reset),
        .busy         (busy),
        .locked       (locked),
        .done         (done),
        .sync_fail    (sync_fail),
        .aborted      (aborted),
        .word_count   (word_count),
        .err_count    (err_count)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------------
    // Counters and check helper
    // ------------------------------------------------------------------------
    int n_vec  = 0;
    int n_fail = 0;
    int done_seen = 0;
    int mask_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: a test run seen as a sequence of phases
    // ------------------------------------------------------------------------
    typedef enum int {P_IDLE, P_SEED, P_SYNC, P_RUN, P_END} phase_t;
    phase_t ph = P_IDLE;
    int     m_mode = 0, m_lock = 0, m_sf = 0, m_ab = 0;
    longint m_len = 0, m_words = 0, m_errs = 0;
    int     seed_left = 0, streak = 0, elapsed = 0;
    int     m_pending = 0;

    initial forever begin
        @(posedge clock or negedge reset);
        if (reset !== 1'b1) begin
            ph = P_IDLE; m_mode = 0; m_lock = 0; m_sf = 0; m_ab = 0;
            m_len = 0; m_words = 0; m_errs = 0; m_pending = 0;
        end else begin
            // injection one-shot, judged on the phase before this edge
            if (ph != P_RUN)                     m_pending = 0;
            else if (m_pending != 0 && rx_valid) m_pending = 0;
`ifdef ERR_INJECT_EN
            else if (inject_req)                 m_pending = 1;
`endif
            case (ph)
                P_IDLE: if (start) begin
                    m_mode = int'(mode_sel); m_len = longint'(test_len);
                    m_words = 0; m_errs = 0; m_lock = 0; m_sf = 0; m_ab = 0;
                    seed_left = SEED_CYC; ph = P_SEED;
                end
                P_SEED: if (abort) begin m_ab = 1; ph = P_IDLE; end
                else begin
                    seed_left--;
                    if (seed_left == 0) begin ph = P_SYNC; streak = 0; elapsed = 0; end
                end
                P_SYNC: if (abort) begin m_ab = 1; ph = P_IDLE; end
                else begin
                    elapsed++;
                    if (rx_valid) streak = (rx_err == '0) ? streak + 1 : 0;
                    if (streak >= LOCK_CNT)       begin m_lock = 1; ph = P_RUN; end
                    else if (elapsed >= SYNC_TMO) begin m_sf = 1;   ph = P_END; end
                end
                P_RUN: if (abort) begin m_ab = 1; ph = P_IDLE; end
                else if (m_len == 0) ph = P_END;
                else if (rx_valid) begin
                    m_words++;
                    m_errs = m_errs + $countones(rx_err);
                    if (m_errs > ERR_MAX) m_errs = ERR_MAX;
                    if (m_words == m_len) ph = P_END;
                end
                default: ph = P_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Compare process: every output, every falling edge
    // ------------------------------------------------------------------------
    initial forever begin
        @(negedge clock);
        chk("gen_reset",    gen_reset,    (ph == P_IDLE || ph == P_SEED || ph == P_END));
        chk("busy",         busy,         (ph == P_SEED || ph == P_SYNC || ph == P_RUN));
        chk("done",         done,         (ph == P_END));
        chk("prbs_control", prbs_control, m_mode);
        chk("locked",       locked,       m_lock);
        chk("sync_fail",    sync_fail,    m_sf);
        chk("aborted",      aborted,      m_ab);
        chk("word_count",   word_count,   m_words);
        chk("err_count",    err_count,    m_errs);
`ifdef ERR_INJECT_EN
        chk("inject_mask",  inject_mask,  (m_pending != 0 && rx_valid && ph == P_RUN) ? 1 : 0);
        if (inject_mask != '0) mask_seen++;
`endif
        if (done === 1'b1) done_seen++;
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 ns after the rising edge)
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic word(input logic [PAT_W-1:0] e);
        rx_valid = 1'b1; rx_err_drv = e;
        step();
        rx_valid = 1'b0; rx_err_drv = '0;
    endtask

    task automatic do_start(input logic m, input logic [CNT_W-1:0] len);
        start = 1'b1; mode_sel = m; test_len = len;
        step();
        // later changes must be ignored by the DUT
        start = 1'b0; mode_sel = ~m; test_len = len + 7;
    endtask

    task automatic seed_and_lock();
        step(); step();
        repeat (LOCK_CNT) word('0);
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            step();
            cycles++;
        end
        if (done !== 1'b1) chk("done_timeout", 0, 1);
    endtask

    int d0, n;

    initial begin
        // reset state
        repeat (3) step();
        chk("rst_gen_reset", gen_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_word_count", word_count, 0);
        reset = 1'b1;
        step();

        // normal PRBS-7 run: 100 words, two errored bits on word 10
        d0 = done_seen;
        do_start(1'b1, 100);
        chk("t1_prbs_control", prbs_control, 1);
        chk("t1_busy", busy, 1);
        seed_and_lock();
        chk("t1_locked", locked, 1);
        for (int i = 1; i <= 100; i++) word((i == 10) ? 13'h0003 : 13'h0000);
        repeat (3) step();
        chk("t1_word_count", word_count, 100);
        chk("t1_err_count", err_count, 2);
        chk("t1_prbs_hold", prbs_control, 1);
        chk("t1_locked_hold", locked, 1);
        chk("t1_done_pulses", done_seen - d0, 1);

        // lock needs 16 consecutive clean words
        do_start(1'b0, 3);
        step(); step();
        repeat (15) word('0);
        word(13'h0100);
        repeat (15) word('0);
        chk("t2_not_locked_yet", locked, 0);
        word('0);
        chk("t2_locked", locked, 1);
        chk("t2_prbs_control", prbs_control, 0);
        repeat (3) word(13'h1001);
        repeat (2) step();
        chk("t2_err_count", err_count, 6);
        chk("t2_word_count", word_count, 3);

        // sync timeout with every word errored
        d0 = done_seen;
        do_start(1'b0, 10);
        rx_valid = 1'b1; rx_err_drv = 13'h1FFF;
        wait_done(1100, n);
        rx_valid = 1'b0; rx_err_drv = '0;
        chk("t3_cycles_to_done", n, 1 + SEED_CYC + SYNC_TMO - 1);
        chk("t3_sync_fail", sync_fail, 1);
        chk("t3_locked", locked, 0);
        chk("t3_word_count", word_count, 0);
        repeat (2) step();
        chk("t3_done_pulses", done_seen - d0, 1);
        chk("t3_sync_fail_sticky", sync_fail, 1);

        // abort at word 50 of 100, start while busy ignored
        d0 = done_seen;
        do_start(1'b1, 100);
        seed_and_lock();
        for (int i = 1; i <= 50; i++) word((i % 7 == 0) ? 13'h0001 : 13'h0000);
        start = 1'b1; mode_sel = 1'b0; step(); start = 1'b0;
        chk("t4_start_ignored_prbs", prbs_control, 1);
        chk("t4_start_ignored_busy", busy, 1);
        abort = 1'b1; rx_valid = 1'b1; rx_err_drv = 13'h0001;
        step();
        abort = 1'b0; rx_valid = 1'b0; rx_err_drv = '0;
        chk("t4_aborted", aborted, 1);
        chk("t4_busy", busy, 0);
        chk("t4_word_count", word_count, 50);
        chk("t4_err_count", err_count, 7);
        repeat (3) step();
        chk("t4_no_done", done_seen - d0, 0);
        do_start(1'b0, 20);
        chk("t4_restart_busy", busy, 1);
        chk("t4_restart_aborted", aborted, 0);
        chk("t4_restart_words", word_count, 0);

        // reset in the middle of RUN
        seed_and_lock();
        repeat (5) word(13'h0010);
        d0 = done_seen;
        reset = 1'b0; #1;
        chk("t5_gen_reset", gen_reset, 1);
        chk("t5_busy", busy, 0);
        chk("t5_locked", locked, 0);
        chk("t5_word_count", word_count, 0);
        chk("t5_err_count", err_count, 0);
        chk("t5_prbs_control", prbs_control, 0);
        repeat (2) step();
        reset = 1'b1;
        repeat (2) step();
        chk("t5_no_done", done_seen - d0, 0);

        // zero-length test ends on first RUN cycle, word there not counted
        do_start(1'b1, 0);
        seed_and_lock();
        word(13'h1FFF);
        chk("t6_done", done, 1);
        chk("t6_word_count", word_count, 0);
        chk("t6_err_count", err_count, 0);
        repeat (2) step();

`ifdef ERR_INJECT_EN
        // one injected error looped back through clean data
        loop_en = 1'b1;
        mask_seen = 0;
        do_start(1'b0, 10);
        seed_and_lock();
        repeat (4) word('0);
        inject_req = 1'b1; word('0);
        step();                       // merged request while armed
        inject_req = 1'b0;
        repeat (5) word('0);
        repeat (2) step();
        chk("t7_err_count", err_count, 1);
        chk("t7_mask_once", mask_seen, 1);
        loop_en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
